// File: rtl/reg_file_dump.sv
// rtl/reg_file_dump.sv - register file debug dump engine; optional checksum word via REG_FILE_DUMP_CHECKSUM_EN
module reg_file_dump #(
   parameter int DAT_W    = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_rf_rd_addr,
   input  logic [DAT_W-1:0]  i_rf_rd_dat,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DAT_W-1:0]  o_dat,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last,
   output logic              o_done
);

`ifdef REG_FILE_DUMP_CHECKSUM_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_CSUM = 2'd2, S_DRAIN = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd3} state_t;
`endif

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
`ifdef REG_FILE_DUMP_CHECKSUM_EN
   logic [DAT_W-1:0]  r_acc;
`endif
   logic              w_ld;
   logic              w_hs;
   logic              w_last_idx;

   // output register is empty or being consumed on this edge
   assign w_ld       = ~o_valid | i_ready;
   assign w_hs       = o_valid & i_ready;
   // termination is by compare against the last index, never by counter wrap
   assign w_last_idx = (r_cnt == ADDR_W'(NUM_REGS - 1));

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state logic and register file read address
   always_comb begin
      w_state_nxt  = r_state;
      o_rf_rd_addr = '0;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            o_rf_rd_addr = r_cnt;
            if (w_ld && w_last_idx) begin
`ifdef REG_FILE_DUMP_CHECKSUM_EN
               w_state_nxt = S_CSUM;
`else
               w_state_nxt = S_DRAIN;
`endif
            end
         end
`ifdef REG_FILE_DUMP_CHECKSUM_EN
         S_CSUM: begin
            if (w_ld) w_state_nxt = S_DRAIN;
         end
`endif
         S_DRAIN: begin
            if (w_hs) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // stream output register, walk counter, accumulator and status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
`ifdef REG_FILE_DUMP_CHECKSUM_EN
         r_acc   <= '0;
`endif
         o_busy  <= 1'b0;
         o_valid <= 1'b0;
         o_dat   <= '0;
         o_addr  <= '0;
         o_last  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_cnt  <= '0;
`ifdef REG_FILE_DUMP_CHECKSUM_EN
                  r_acc  <= '0;
`endif
                  o_busy <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_ld) begin
                  o_dat   <= i_rf_rd_dat;
                  o_addr  <= r_cnt;
                  o_valid <= 1'b1;
                  r_cnt   <= r_cnt + ADDR_W'(1);
`ifdef REG_FILE_DUMP_CHECKSUM_EN
                  r_acc   <= r_acc ^ i_rf_rd_dat;
`else
                  if (w_last_idx) o_last <= 1'b1;
`endif
               end
            end
`ifdef REG_FILE_DUMP_CHECKSUM_EN
            S_CSUM: begin
               if (w_ld) begin
                  o_dat   <= r_acc;
                  o_addr  <= '0;
                  o_last  <= 1'b1;
                  o_valid <= 1'b1;
               end
            end
`endif
            S_DRAIN: begin
               if (w_hs) begin
                  o_valid <= 1'b0;
                  o_last  <= 1'b0;
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_dump.sv
// tb/tb_reg_file_dump.sv - self-checking bench for reg_file_dump
module tb_reg_file_dump;

`ifdef REG_FILE_DUMP_CHECKSUM_EN
   localparam int CSUM = 1;
`else
   localparam int CSUM = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic        o_busy;
   logic [4:0]  o_rf_rd_addr;
   logic [31:0] i_rf_rd_dat;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_dat;
   logic [4:0]  o_addr;
   logic        o_last;
   logic        o_done;

   logic [31:0] rf [32];

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      logic        l;
   } word_t;

   word_t       exp_q [$];
   logic        exp_busy = 1'b0;
   logic        exp_done = 1'b0;
   logic        held_v   = 1'b0;
   logic [31:0] held_d;
   logic [4:0]  held_a;
   logic        held_l;

   always #5 clk = ~clk;

   assign i_rf_rd_dat = rf[o_rf_rd_addr];

   reg_file_dump #(.DAT_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .o_busy       (o_busy),
      .o_rf_rd_addr (o_rf_rd_addr),
      .i_rf_rd_dat  (i_rf_rd_dat),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_dat        (o_dat),
      .o_addr       (o_addr),
      .o_last       (o_last),
      .o_done       (o_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model: a dump is a list of words computed from the register file contents at start;
   // each handshake consumes the next word, the final handshake yields done one cycle later
   always @(negedge clk) begin
      logic        cur_busy;
      word_t       w;
      logic [31:0] acc;
      if (rst) begin
         exp_q.delete();
         exp_busy = 1'b0;
         exp_done = 1'b0;
         held_v   = 1'b0;
         chk("rst_valid", o_valid, 0);
         chk("rst_busy", o_busy, 0);
         chk("rst_done", o_done, 0);
         chk("rst_last", o_last, 0);
         chk("rst_dat", o_dat, 0);
         chk("rst_addr", o_addr, 0);
         chk("rst_rdaddr", o_rf_rd_addr, 0);
      end else begin
         chk("busy", o_busy, exp_busy);
         chk("done", o_done, exp_done);
         if (held_v) begin
            chk("stall_valid", o_valid, 1);
            chk("stall_dat", o_dat, held_d);
            chk("stall_addr", o_addr, held_a);
            chk("stall_last", o_last, held_l);
         end
         cur_busy = exp_busy;
         exp_done = 1'b0;
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_word", 1, 0);
            end else begin
               w = exp_q.pop_front();
               chk("word_addr", o_addr, w.a);
               chk("word_dat", o_dat, w.d);
               chk("word_last", o_last, w.l);
               if (w.l) begin
                  exp_done = 1'b1;
                  exp_busy = 1'b0;
               end
            end
         end
         held_v = o_valid && !i_ready;
         held_d = o_dat;
         held_a = o_addr;
         held_l = o_last;
         if (!cur_busy && i_start) begin
            exp_busy = 1'b1;
            acc = 32'h0;
            for (int k = 0; k < 32; k++) begin
               w.a = 5'(k);
               w.d = rf[k];
               w.l = (CSUM == 0) && (k == 31);
               exp_q.push_back(w);
               acc = acc ^ rf[k];
            end
            if (CSUM != 0) begin
               w.a = 5'd0;
               w.d = acc;
               w.l = 1'b1;
               exp_q.push_back(w);
            end
         end
      end
   end

   // entered and left at 1 time unit after a rising edge
   task automatic run_dump(input int stall_idx, input int stall_n, input int busy_idx,
                           input int rst_idx, input int exp_lat, input bit csum_lit);
      int n      = 0;
      int stalls = stall_n;
      bit done_seen = 0;
      bit pulsed    = 0;
      bit rst_hit   = 0;
      i_ready = 1'b1;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      while (!done_seen && !rst_hit && n < 300) begin
         @(posedge clk); #1;
         n++;
         i_start = 1'b0;
         if (n == 1) begin
            chk("x0_valid", o_valid, 1);
            chk("x0_addr", o_addr, 0);
            chk("x0_dat", o_dat, 32'h0);
         end
         if (o_done) begin
            done_seen = 1;
            chk("latency", n, exp_lat);
            chk("queue_empty", exp_q.size(), 0);
         end
`ifdef REG_FILE_DUMP_CHECKSUM_EN
         if (csum_lit && o_valid && o_last) begin
            chk("csum_dat", o_dat, 32'h06675229);
            chk("csum_addr", o_addr, 0);
         end
`endif
         if (o_valid && int'(o_addr) == stall_idx && stalls > 0) begin
            i_ready = 1'b0;
            stalls--;
            chk("bp_dat", o_dat, 32'hAAAAAAAA);
         end else begin
            i_ready = 1'b1;
         end
         if (o_valid && int'(o_addr) == busy_idx && !pulsed) begin
            i_start = 1'b1;
            pulsed  = 1;
         end
         if (o_valid && int'(o_addr) == rst_idx) begin
            rst_hit = 1;
            rst = 1'b1;
            #1;
            chk("arst_valid", o_valid, 0);
            chk("arst_busy", o_busy, 0);
            chk("arst_addr", o_addr, 0);
            @(posedge clk); #1;
            rst = 1'b0;
            i_ready = 1'b1;
            for (int c = 0; c < 5; c++) begin
               @(posedge clk); #1;
               chk("post_rst_done", o_done, 0);
               chk("post_rst_valid", o_valid, 0);
            end
         end
      end
      i_start = 1'b0;
      i_ready = 1'b1;
      if (!done_seen && !rst_hit) chk("timeout", 0, 1);
   endtask

   initial begin
      rst     = 1'b1;
      i_start = 1'b0;
      i_ready = 1'b1;
      for (int k = 0; k < 32; k++) rf[k] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", o_busy, 0);
      chk("reset_valid", o_valid, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // full dump with the three preloaded registers
      rf[1]  = 32'h12345678;
      rf[15] = 32'hCAFEBABE;
      rf[31] = 32'hDEADBEEF;
      run_dump(-1, 0, -1, -1, 33 + CSUM, 1);
      repeat (2) @(posedge clk);
      #1;

      // distinct data everywhere except x0, backpressure on index 2
      for (int k = 1; k < 32; k++) rf[k] = (32'h01010101 * 32'(k)) ^ 32'h5A000000;
      rf[2] = 32'hAAAAAAAA;
      run_dump(2, 3, -1, -1, 36 + CSUM, 0);
      repeat (2) @(posedge clk);
      #1;

      // start request while busy is ignored
      run_dump(-1, 0, 10, -1, 33 + CSUM, 0);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("no_second_busy", o_busy, 0);
         chk("no_second_valid", o_valid, 0);
      end

      // reset mid-dump, then a complete dump
      run_dump(-1, 0, -1, 20, 0, 0);
      run_dump(-1, 0, -1, -1, 33 + CSUM, 0);
      repeat (3) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
